// File: rtl/sd_block_reader.sv
// rtl/sd_block_reader.sv - SD SPI-mode CMD17 single-block reader driving the SPI byte engine; SD_SDSC_ADDR_EN selects byte addressing
module sd_block_reader #(
  parameter logic [7:0]  SPI_DIV    = 8'd1,
  parameter int          R1_POLL    = 8,
  parameter logic [15:0] TOKEN_POLL = 16'd4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] lba,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        wr_en,
  output logic [8:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic [11:0] spi_addr,
  output logic [7:0]  spi_dout,
  output logic        spi_iowr,
  input  logic        spi_ready,
  input  logic [7:0]  spi_din
);

  // engine ready lags the toggle, so each write is held this long before ready is trusted
  localparam logic [1:0]  HOLD       = 2'd3;
  localparam logic [11:0] A_CS       = 12'h0B0;
  localparam logic [11:0] A_DIV      = 12'h0B1;
  localparam logic [11:0] A_DATA     = 12'h0B2;
  localparam logic [15:0] R1_LAST    = 16'(R1_POLL - 1);
  localparam logic [15:0] TOKEN_LAST = TOKEN_POLL - 16'd1;

  typedef enum logic [3:0] {
    S_IDLE, S_DIV, S_CS_ON, S_CMD, S_R1, S_TOKEN,
    S_DATA, S_CRC, S_CS_OFF, S_TAIL, S_DONE
  } state_t;

  state_t      state, state_n;
  logic [1:0]  hold_cnt;
  logic [15:0] cnt, cnt_n;
  logic [8:0]  wr_cnt;
  logic [31:0] lba_q, arg;
  logic        reg_wr, xfer_done, issue, sample;
  logic        err_set;
  logic [1:0]  err_val;
  logic [11:0] iss_addr;
  logic [7:0]  iss_data;

`ifdef SD_SDSC_ADDR_EN
  assign arg = {lba_q[22:0], 9'b0};
`else
  assign arg = lba_q;
`endif

  // a write finishes once HOLD has elapsed; byte transfers additionally wait for the engine
  assign reg_wr    = (state == S_DIV) || (state == S_CS_ON) || (state == S_CS_OFF);
  assign xfer_done = (state != S_IDLE) && (state != S_DONE) && (hold_cnt == 2'd0) &&
                     (reg_wr || spi_ready);
  assign sample    = (state == S_DATA) && xfer_done;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state and error detection
  always_comb begin
    state_n = state;
    err_set = 1'b0;
    err_val = 2'd0;
    case (state)
      S_IDLE:   if (start) state_n = S_DIV;
      S_DIV:    if (xfer_done) state_n = S_CS_ON;
      S_CS_ON:  if (xfer_done) state_n = S_CMD;
      S_CMD:    if (xfer_done && cnt == 16'd5) state_n = S_R1;
      S_R1: begin
        if (xfer_done) begin
          if (spi_din == 8'h00) begin
            state_n = S_TOKEN;
          end else if (spi_din != 8'hFF) begin
            state_n = S_CS_OFF;
            err_set = 1'b1;
            err_val = 2'd1;
          end else if (cnt == R1_LAST) begin
            state_n = S_CS_OFF;
            err_set = 1'b1;
            err_val = 2'd2;
          end
        end
      end
      S_TOKEN: begin
        if (xfer_done) begin
          if (spi_din == 8'hFE) begin
            state_n = S_DATA;
          end else if (cnt == TOKEN_LAST) begin
            state_n = S_CS_OFF;
            err_set = 1'b1;
            err_val = 2'd3;
          end
        end
      end
      S_DATA:   if (xfer_done && wr_cnt == 9'h1FF) state_n = S_CRC;
      S_CRC:    if (xfer_done && cnt == 16'd1) state_n = S_CS_OFF;
      S_CS_OFF: if (xfer_done) state_n = S_TAIL;
      S_TAIL:   if (xfer_done) state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Status outputs and the register write to launch on this edge
  always_comb begin
    busy     = (state != S_IDLE) && (state != S_DONE);
    done     = (state == S_DONE);
    cnt_n    = (state_n != state) ? 16'd0 : cnt + 16'd1;
    issue    = (state_n != S_IDLE) && (state_n != S_DONE) && ((state_n != state) || xfer_done);
    iss_addr = A_DATA;
    iss_data = 8'hFF;
    case (state_n)
      S_DIV:    begin iss_addr = A_DIV; iss_data = SPI_DIV; end
      S_CS_ON:  begin iss_addr = A_CS;  iss_data = 8'h01;   end
      S_CS_OFF: begin iss_addr = A_CS;  iss_data = 8'h00;   end
      S_CMD: begin
        case (cnt_n[2:0])
          3'd0:    iss_data = 8'h51;
          3'd1:    iss_data = arg[31:24];
          3'd2:    iss_data = arg[23:16];
          3'd3:    iss_data = arg[15:8];
          3'd4:    iss_data = arg[7:0];
          default: iss_data = 8'hFF;
        endcase
      end
      default: ;
    endcase
  end

  // Engine port, hold timer, byte counters, error flags and buffer writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= 2'd0;
      cnt      <= 16'd0;
      wr_cnt   <= 9'd0;
      lba_q    <= 32'd0;
      err      <= 1'b0;
      err_code <= 2'd0;
      wr_en    <= 1'b0;
      wr_addr  <= 9'd0;
      wr_data  <= 8'd0;
      spi_addr <= 12'd0;
      spi_dout <= 8'd0;
      spi_iowr <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (state == S_IDLE && start) begin
        lba_q    <= lba;
        err      <= 1'b0;
        err_code <= 2'd0;
        wr_cnt   <= 9'd0;
      end
      if (err_set) begin
        err      <= 1'b1;
        err_code <= err_val;
      end
      if (issue) begin
        spi_iowr <= ~spi_iowr;
        spi_addr <= iss_addr;
        spi_dout <= iss_data;
        hold_cnt <= HOLD;
        cnt      <= cnt_n;
      end else if (hold_cnt != 2'd0) begin
        hold_cnt <= hold_cnt - 2'd1;
      end
      if (sample) begin
        wr_en   <= 1'b1;
        wr_addr <= wr_cnt;
        wr_data <= spi_din;
        wr_cnt  <= wr_cnt + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_sd_block_reader.sv
// tb/tb_sd_block_reader.sv - directed bench for sd_block_reader with SPI engine and SD card model
module tb_sd_block_reader;

  localparam logic [7:0] SPI_DIV     = 8'd1;
  localparam int         ENGINE_CLKS = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] lba;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [11:0] spi_addr;
  logic [7:0]  spi_dout;
  logic        spi_iowr;
  logic        spi_ready = 1'b1;
  logic [7:0]  spi_din = 8'hFF;

  sd_block_reader #(.SPI_DIV(SPI_DIV), .R1_POLL(8), .TOKEN_POLL(16'd4096)) dut (
    .clk(clk), .reset(reset), .start(start), .lba(lba),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .spi_addr(spi_addr), .spi_dout(spi_dout), .spi_iowr(spi_iowr),
    .spi_ready(spi_ready), .spi_din(spi_din)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // card behaviour: 0 normal, 1 R1=0x05, 2 MISO stuck 0xFF, 3 token never arrives
  int mode = 0;

  // engine + card model state; log entries are {kind[1:0], cs, data}, kind 0=B0 1=B1 2=B2
  logic        prev_iowr = 1'b0;
  logic        cs = 1'b0;
  int          idx = 0;
  int          busy_cnt = 0;
  logic [7:0]  pending = 8'hFF;
  logic [10:0] xlog[$];

  function automatic logic [7:0] card_byte(input int i);
    logic [8:0] k;
    if (mode == 2) return 8'hFF;
    if (i == 7) return (mode == 1) ? 8'h05 : 8'h00;
    if (mode == 3 && i >= 8) return 8'hFF;
    if (i == 10) return 8'hFE;
    if (i >= 11 && i < 523) begin
      k = 9'(i - 11);
      return k[7:0] ^ 8'h5A;
    end
    return 8'hFF;
  endfunction

  // SPI engine: reacts to each toggle, drops ready for the byte time, returns the card byte
  always @(posedge clk) begin
    if (reset) begin
      prev_iowr <= 1'b0;
      spi_ready <= 1'b1;
      busy_cnt  <= 0;
    end else begin
      prev_iowr <= spi_iowr;
      if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
        if (busy_cnt == 1) begin
          spi_ready <= 1'b1;
          spi_din   <= pending;
        end
      end
      if (spi_iowr != prev_iowr) begin
        if (spi_addr == 12'h0B0) begin
          cs <= spi_dout[0];
          if (spi_dout[0]) idx <= 0;
          xlog.push_back({2'd0, 1'b0, spi_dout});
        end else if (spi_addr == 12'h0B1) begin
          xlog.push_back({2'd1, 1'b0, spi_dout});
        end else if (spi_addr == 12'h0B2) begin
          xlog.push_back({2'd2, cs, spi_dout});
          pending   <= cs ? card_byte(idx) : 8'hFF;
          if (cs) idx <= idx + 1;
          spi_ready <= 1'b0;
          busy_cnt  <= ENGINE_CLKS;
        end
      end
    end
  end

  logic [16:0] sb[$];
  int          base = 0;
  int          wr_seen = 0;
  int          done_seen = 0;
  logic        prev_wr = 1'b0;
  int          n_cs, n_nocs, n_b0, n_b1;
  logic [7:0]  b0_seq, b1_val;
  logic [47:0] cmd_got;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_arg(input logic [31:0] l);
`ifdef SD_SDSC_ADDR_EN
    return {l[22:0], 9'b0};
`else
    return l;
`endif
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({busy, done, err, err_code, wr_en, wr_addr, wr_data, spi_addr, spi_dout, spi_iowr});
  endfunction

  task automatic push_block();
    logic [8:0] k;
    for (int i = 0; i < 512; i++) begin
      k = 9'(i);
      sb.push_back({k, k[7:0] ^ 8'h5A});
    end
  endtask

  task automatic step();
    logic [16:0] e;
    @(negedge clk);
    if (wr_en) begin
      wr_seen++;
      check("wr_en_gap", prev_wr, 0);
      if (sb.size() == 0) begin
        check("wr_unexpected", wr_addr, 9'h1FF + 1);
      end else begin
        e = sb.pop_front();
        check("wr_addr", wr_addr, e[16:8]);
        check("wr_data", wr_data, e[7:0]);
      end
    end
    prev_wr = wr_en;
    if (done) done_seen++;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!done && n < budget);
    check("done_within_budget", done, 1);
  endtask

  task automatic start_xfer(input logic [31:0] l);
    logic nt;
    @(negedge clk);
    lba = l;
    start = 1'b1;
    nt = !spi_iowr;
    base = xlog.size();
    wr_seen = 0;
    done_seen = 0;
    prev_wr = 1'b0;
    @(posedge clk);
    #1;
    check("start_busy", busy, 1);
    check("start_toggle", spi_iowr, nt);
    check("start_b1_addr", spi_addr, 12'h0B1);
    check("start_err_clear", err, 0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic analyze();
    logic [10:0] e;
    n_cs = 0; n_nocs = 0; n_b0 = 0; n_b1 = 0;
    b0_seq = 8'd0; b1_val = 8'd0; cmd_got = 48'd0;
    for (int j = base; j < xlog.size(); j++) begin
      e = xlog[j];
      case (e[10:9])
        2'd0: begin b0_seq = {b0_seq[6:0], e[0]}; n_b0++; end
        2'd1: begin n_b1++; b1_val = e[7:0]; end
        default: begin
          if (e[8]) begin
            if (n_cs < 6) cmd_got = {cmd_got[39:0], e[7:0]};
            n_cs++;
          end else begin
            n_nocs++;
          end
        end
      endcase
    end
  endtask

  task automatic finish_checks(input logic [31:0] l, input logic [1:0] code, input int exp_cs,
                               input int exp_wr);
    check("busy_at_done", busy, 0);
    check("err_flag", err, (code != 2'd0));
    check("err_code", err_code, code);
    check("wr_count", wr_seen, exp_wr);
    check("scoreboard_empty", sb.size(), 0);
    analyze();
    check("cmd_bytes", cmd_got, {8'h51, exp_arg(l), 8'hFF});
    check("cs_transfers", n_cs, exp_cs);
    check("tail_transfers", n_nocs, 1);
    check("b0_writes", n_b0, 2);
    check("b0_on_then_off", b0_seq[1:0], 2'b10);
    check("b1_writes", n_b1, 1);
    check("b1_value", b1_val, SPI_DIV);
    step();
    check("done_single_pulse", done, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    lba   = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 0);
    @(negedge clk);
    reset = 1'b0;

    // normal read
    mode = 0;
    start_xfer(32'h0000_1234);
    push_block();
    wait_done(10000);
    finish_checks(32'h0000_1234, 2'd0, 525, 512);

    // card rejects the command
    mode = 1;
    start_xfer(32'h0000_0042);
    wait_done(2000);
    finish_checks(32'h0000_0042, 2'd1, 8, 0);

    // no R1 ever
    mode = 2;
    start_xfer(32'h0000_0043);
    wait_done(2000);
    finish_checks(32'h0000_0043, 2'd2, 14, 0);

    // R1 fine, no start token
    mode = 3;
    start_xfer(32'h0000_0044);
    wait_done(40000);
    finish_checks(32'h0000_0044, 2'd3, 4104, 0);

    // start during DATA is ignored, then reset aborts at byte 100
    mode = 0;
    start_xfer(32'h0000_0777);
    push_block();
    n = 0;
    while (wr_seen < 50 && n < 10000) begin step(); n++; end
    check("reach_byte50", wr_seen, 50);
    start = 1'b1;
    lba = 32'h0000_FFFF;
    step();
    start = 1'b0;
    repeat (20) step();
    check("busy_after_ignored_start", busy, 1);
    analyze();
    check("no_restart_b1", n_b1, 1);
    n = 0;
    while (wr_seen < 100 && n < 10000) begin step(); n++; end
    check("reach_byte100", wr_seen, 100);
    reset = 1'b1;
    #1;
    check("abort_outputs", all_outs(), 0);
    repeat (3) step();
    check("abort_outputs_held", all_outs(), 0);
    check("no_done_on_abort", done_seen, 0);
    reset = 1'b0;
    sb.delete();

    // full transfer after the abort
    start_xfer(32'h0000_0001);
    push_block();
    wait_done(10000);
    finish_checks(32'h0000_0001, 2'd0, 525, 512);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
